multi_key_tone_beep: RTL and testbench
======================================

# multi_key_tone_beep

Multi-key buzzer controller: KEY_NUM active-low push keys are debounced independently, and each key selects its own square-wave tone on the single `beep` output. It is the parametrised successor to the single-key beep path and sits directly behind the board key pins and in front of the buzzer pin, in the single-ended `sys_clk` domain. Three runtime play modes are supported: level, toggle and one-shot. Key-event and status outputs are exported for other logic.

## Interface
- `KEY_NUM`, 4: number of keys/tones, 1..8.
- `DEBOUNCE_CNT`, 2_000_000: consecutive stable cycles required to accept a key level (10 ms at 200 MHz).
- `BASE_HALF`, 100_000: half period, in cycles, of tone 0; tone k half period = `BASE_HALF*(k+1)`.
- `ONESHOT_CYC`, 40_000_000: tone length in one-shot mode (200 ms).
- `sys_clk` in 1: single clock, all logic rising-edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `key` in KEY_NUM: raw keys, active-low, asynchronous to `sys_clk`.
- `mode` in 2: 0 = level, 1 = toggle, 2 = one-shot, 3 = reserved (treated as 0); sampled only in IDLE.
- `beep` out 1: buzzer drive, active-high square wave; low when silent.
- `busy` out 1: high while in TONE state.
- `key_code` out clog2(KEY_NUM) (min 1): index of the last accepted press.
- `key_valid` out 1: one-cycle pulse per accepted press, concurrent with the `key_code` update.

## Operation
- Each key bit uses a 2-flop synchroniser followed by a debounce counter.
- The filtered level changes only after the synchronised input has differed from it for `DEBOUNCE_CNT` consecutive cycles; any bounce restarts the count.
- A press is a filtered 1->0 edge. If several keys are pressed in the same cycle, the lowest index wins; the other presses are ignored.
- FSM states:
  - IDLE: a press loads `cur_key`, latches `mode` into `act_mode`, and moves to TONE.
  - TONE: generates tone `cur_key`. Exit depends on `act_mode`:
    - level: exit to IDLE when the filtered `cur_key` is released. If another key is held at release, go straight to TONE with the lowest held index; no IDLE cycle.
    - toggle: a press of `cur_key` -> IDLE. A press of a different key -> stay in TONE, switch to that key, and restart the tone phase.
    - one-shot: exit to IDLE after `ONESHOT_CYC` cycles. A new press restarts the duration with the new key (retrigger).
- Tone generator:
  - The half-period counter clears on every TONE entry or key switch.
  - `beep` is forced high on the entry/switch cycle, then toggles each time the counter reaches half period - 1.
  - `beep` is forced low in IDLE.
- Counter widths are sized with clog2 of their maximum; no wrap-around occurs within one period.
- `mode` changes during TONE are ignored until the next IDLE.
- Reset values: `beep`=0, `busy`=0, `key_code`=0, `key_valid`=0, FSM=IDLE, filtered levels=1 (released), all counters 0.
- Reset mid-tone silences `beep` asynchronously. A key held through reset release must be re-accepted: its level is filtered as released, and the press is detected after `DEBOUNCE_CNT` cycles.

## Timing
- Press latency: a raw falling edge stable from cycle 0 gives `key_valid` at cycle 2 + `DEBOUNCE_CNT` (±1).
- `key_valid`, `key_code`, the FSM state change and the `beep` rise are registered on the same cycle, so `busy` rises with them.
- Tone period is exactly `2*BASE_HALF*(k+1)` cycles with a 50 % duty cycle.
- One-shot: `beep` is forced low, and `busy` falls, at cycle `ONESHOT_CYC` after `key_valid`.
- Release latency (level mode): `busy` falls 2 + `DEBOUNCE_CNT` cycles after the raw rising edge.

## Structure
- Shared package `key_beep_pkg`: mode encodings `MODE_LEVEL`/`MODE_TOGGLE`/`MODE_ONESHOT`, FSM state encoding `ST_IDLE`/`ST_TONE`.
- Sub-module `key_debounce` (parameter `CNT_MAX`; ports `sys_clk`, `sys_rst_n`, `key`, `key_filter`), instantiated KEY_NUM times in a generate loop.
- The top level contains the edge detect, priority encoder, FSM, tone counter and duration counter.

## Test plan
All scenarios use `KEY_NUM`=4, `DEBOUNCE_CNT`=8, `BASE_HALF`=4, `ONESHOT_CYC`=64.
- Bounce rejection: key[1] toggles every 5 cycles for 40 cycles, then stays low -> exactly one `key_valid`, with `key_code`=1, about 10 cycles after the final edge; `beep` period = 16 cycles.
- Level mode with priority: keys 2 and 0 pressed in the same cycle -> `key_code`=0, period 8. Release key 0 while key 2 is held -> switch to period 24 with no low gap. Release key 2 -> `busy`=0 and `beep`=0.
- Toggle mode: press and release key 3 -> tone period 32 continues after release. Press key 1 -> period 16, phase restarts high. Press key 1 again -> IDLE.
- One-shot retrigger: press key 0, then press key 2 at cycle 30 -> `busy` stays high until 64 cycles after the second `key_valid`, then `beep`=0.
- Reset mid-tone: assert `sys_rst_n` low asynchronously during TONE -> `beep`, `busy` and `key_valid` are 0 immediately. Hold the key across reset release -> a new press is accepted after about 10 cycles.
- Mode change during TONE: switch `mode` from 1 to 2 while toggle tone is active -> toggle behaviour persists until IDLE, and the next press uses one-shot.

Source files
------------

// File: rtl/key_beep_pkg.sv
// Shared types for the multi-key tone buzzer: play modes, FSM states
// and a width helper for counters sized from their maximum value.
package key_beep_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL   = 2'd0,
        MODE_TOGGLE  = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TONE = 1'b1
    } state_e;

    // Bits needed to hold values 0..maxv-1, never less than one.
    function automatic int unsigned cw(input int unsigned maxv);
        return (maxv > 1) ? $clog2(maxv) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser and debounce filter.
// Ports: sys_clk, sys_rst_n (async, active-low), key (raw, async),
// key_filter (level accepted after CNT_MAX stable cycles, resets high).
module key_debounce
    import key_beep_pkg::*;
#(
    parameter int unsigned CNT_MAX = 2_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_filter
);

    localparam int unsigned CW = cw(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle where the synchronised input agrees with the filtered
    // level restarts the count, so bounces never accumulate.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= key;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign key_filter = filt_q;

endmodule

// File: rtl/multi_key_tone_beep.sv
// Multi-key buzzer controller: debounced keys select a square-wave tone.
// Ports: sys_clk, sys_rst_n, key[KEY_NUM], mode[2] in; beep, busy,
// key_code (last accepted press), key_valid (press pulse) out.
module multi_key_tone_beep
    import key_beep_pkg::*;
#(
    parameter int unsigned KEY_NUM      = 4,
    parameter int unsigned DEBOUNCE_CNT = 2_000_000,
    parameter int unsigned BASE_HALF    = 100_000,
    parameter int unsigned ONESHOT_CYC  = 40_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [KEY_NUM-1:0]       key,
    input  logic [1:0]               mode,
    output logic                     beep,
    output logic                     busy,
    output logic [cw(KEY_NUM)-1:0]   key_code,
    output logic                     key_valid
);

    localparam int unsigned KW = cw(KEY_NUM);
    localparam int unsigned TW = cw(BASE_HALF * KEY_NUM);
    localparam int unsigned DW = cw(ONESHOT_CYC);
    localparam logic [DW-1:0] DUR_LAST = DW'(ONESHOT_CYC - 1);

    logic [KEY_NUM-1:0] filt;
    logic [KEY_NUM-1:0] filt_prev_q;
    logic [KEY_NUM-1:0] press;
    logic [KEY_NUM-1:0] held;
    logic               press_any;
    logic               held_any;
    logic [KW-1:0]      press_idx;
    logic [KW-1:0]      held_idx;

    state_e        state_q;
    mode_e         act_mode_q;
    logic [KW-1:0] cur_key_q;
    logic [KW-1:0] key_code_q;
    logic          key_valid_q;
    logic          beep_q;
    logic          busy_q;
    logic [TW-1:0] tone_cnt_q;
    logic [DW-1:0] dur_cnt_q;
    logic [TW-1:0] half_last;
    logic          tone_wrap;
    logic          cur_rel;
    logic          dur_last;

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_db
        key_debounce #(
            .CNT_MAX(DEBOUNCE_CNT)
        ) u_db (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key       (key[g]),
            .key_filter(filt[g])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            filt_prev_q <= '1;
        end else begin
            filt_prev_q <= filt;
        end
    end

    assign press = filt_prev_q & ~filt;
    assign held  = ~filt;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        press_any = |press;
        held_any  = |held;
        press_idx = '0;
        held_idx  = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (press[i]) press_idx = KW'(i);
            if (held[i])  held_idx  = KW'(i);
        end
    end

    assign half_last = TW'(BASE_HALF * (32'(cur_key_q) + 1) - 1);
    assign tone_wrap = (tone_cnt_q == half_last);
    assign cur_rel   = filt[cur_key_q];
    assign dur_last  = (dur_cnt_q == DUR_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            act_mode_q  <= MODE_LEVEL;
            cur_key_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            beep_q      <= 1'b0;
            busy_q      <= 1'b0;
            tone_cnt_q  <= '0;
            dur_cnt_q   <= '0;
        end else begin
            key_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    beep_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    tone_cnt_q <= '0;
                    dur_cnt_q  <= '0;
                    if (press_any) begin
                        state_q     <= ST_TONE;
                        act_mode_q  <= (mode == MODE_RSVD) ? MODE_LEVEL
                                                           : mode_e'(mode);
                        cur_key_q   <= press_idx;
                        key_code_q  <= press_idx;
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        beep_q      <= 1'b1;
                    end
                end
                ST_TONE: begin
                    if (tone_wrap) begin
                        tone_cnt_q <= '0;
                        beep_q     <= ~beep_q;
                    end else begin
                        tone_cnt_q <= tone_cnt_q + 1'b1;
                    end
                    unique case (act_mode_q)
                        MODE_TOGGLE: begin
                            if (press_any) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= press_idx;
                                if (press_idx == cur_key_q) begin
                                    state_q    <= ST_IDLE;
                                    beep_q     <= 1'b0;
                                    busy_q     <= 1'b0;
                                    tone_cnt_q <= '0;
                                end else begin
                                    cur_key_q  <= press_idx;
                                    tone_cnt_q <= '0;
                                    beep_q     <= 1'b1;
                                end
                            end
                        end
                        MODE_ONESHOT: begin
                            if (press_any) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= press_idx;
                                cur_key_q   <= press_idx;
                                tone_cnt_q  <= '0;
                                beep_q      <= 1'b1;
                                dur_cnt_q   <= '0;
                            end else if (dur_last) begin
                                state_q    <= ST_IDLE;
                                beep_q     <= 1'b0;
                                busy_q     <= 1'b0;
                                tone_cnt_q <= '0;
                                dur_cnt_q  <= '0;
                            end else begin
                                dur_cnt_q <= dur_cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            // Hand over to another held key without
                            // passing through IDLE.
                            if (cur_rel) begin
                                if (held_any) begin
                                    cur_key_q  <= held_idx;
                                    tone_cnt_q <= '0;
                                    beep_q     <= 1'b1;
                                end else begin
                                    state_q    <= ST_IDLE;
                                    beep_q     <= 1'b0;
                                    busy_q     <= 1'b0;
                                    tone_cnt_q <= '0;
                                end
                            end
                        end
                    endcase
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign beep      = beep_q;
    assign busy      = busy_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_multi_key_tone_beep.sv
// Directed bench for multi_key_tone_beep with KEY_NUM=4,
// DEBOUNCE_CNT=8, BASE_HALF=4, ONESHOT_CYC=64.
module tb_multi_key_tone_beep;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [3:0] key;
    logic [1:0] mode;
    logic       beep;
    logic       busy;
    logic [1:0] key_code;
    logic       key_valid;

    int vectors     = 0;
    int miscompares = 0;
    int nvalid      = 0;

    multi_key_tone_beep #(
        .KEY_NUM     (4),
        .DEBOUNCE_CNT(8),
        .BASE_HALF   (4),
        .ONESHOT_CYC (64)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key      (key),
        .mode     (mode),
        .beep     (beep),
        .busy     (busy),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (key_valid === 1'b1) nvalid <= nvalid + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d required %0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    // Starts on the cycle beep has just gone high with a fresh phase.
    task automatic chk_period(input string tag, input int h);
        tick(h - 1); chk({tag, "_hi_end"}, 32'(beep), 1);
        tick(1);     chk({tag, "_lo_beg"}, 32'(beep), 0);
        tick(h - 1); chk({tag, "_lo_end"}, 32'(beep), 0);
        tick(1);     chk({tag, "_hi_beg"}, 32'(beep), 1);
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < maxc) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_busy_low(input int maxc, output int n);
        n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_rise(input int maxc, output bit ok);
        logic p;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            p = beep;
            tick(1);
            if (p === 1'b0 && beep === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        int n;
        int base;
        bit ok;
        bit gap;

        sys_rst_n = 1'b0;
        key       = 4'hF;
        mode      = 2'd0;
        #2;
        chk("rst_beep", 32'(beep), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_valid", 32'(key_valid), 0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);

        // Bounce on key 1, then a stable press in level mode.
        base = nvalid;
        for (int i = 0; i < 8; i++) begin
            key[1] = 1'(i % 2);
            tick(5);
        end
        chk("bnc_none", 32'(nvalid - base), 0);
        key[1] = 1'b0;
        wait_valid(30, n);
        chk_rng("bnc_lat", n, 9, 11);
        chk("bnc_code", 32'(key_code), 1);
        chk("bnc_busy", 32'(busy), 1);
        chk("bnc_beep", 32'(beep), 1);
        chk_period("bnc_t1", 8);
        chk("bnc_once", 32'(nvalid - base), 1);
        key = 4'hF;
        wait_busy_low(20, n);
        chk_rng("rel_lat", n, 9, 11);
        chk("rel_beep", 32'(beep), 0);

        // Level mode, keys 2 and 0 together.
        key = 4'b1010;
        wait_valid(20, n);
        chk("lvl_valid", 32'(key_valid), 1);
        chk("lvl_code", 32'(key_code), 0);
        chk_period("lvl_t0", 4);
        key = 4'b1011;
        gap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy !== 1'b1) gap = 1'b1;
        end
        chk("lvl_nogap", 32'(gap), 0);
        wait_rise(30, ok);
        chk("lvl_rise", 32'(ok), 1);
        chk_period("lvl_t2", 12);
        key = 4'hF;
        wait_busy_low(20, n);
        chk("lvl_idle", 32'(busy), 0);
        chk("lvl_beep", 32'(beep), 0);

        // Toggle mode.
        mode = 2'd1;
        key  = 4'b0111;
        wait_valid(20, n);
        chk("tgl_code3", 32'(key_code), 3);
        key = 4'hF;
        tick(15);
        chk("tgl_hold", 32'(busy), 1);
        wait_rise(40, ok);
        chk("tgl_rise", 32'(ok), 1);
        chk_period("tgl_t3", 16);
        key = 4'b1101;
        wait_valid(20, n);
        chk("tgl_code1", 32'(key_code), 1);
        chk("tgl_sw_hi", 32'(beep), 1);
        chk_period("tgl_t1", 8);
        key = 4'hF;
        tick(15);
        chk("tgl_still", 32'(busy), 1);
        key = 4'b1101;
        wait_busy_low(20, n);
        chk_rng("tgl_off", n, 9, 11);
        chk("tgl_off_beep", 32'(beep), 0);
        key = 4'hF;
        tick(15);

        // Mode change while a toggle tone plays.
        key = 4'b1110;
        wait_valid(20, n);
        chk("mc_code", 32'(key_code), 0);
        mode = 2'd2;
        key  = 4'hF;
        tick(80);
        chk("mc_persist", 32'(busy), 1);
        key = 4'b1110;
        wait_busy_low(20, n);
        chk("mc_off", 32'(busy), 0);
        key = 4'hF;
        tick(15);
        key = 4'b1011;
        wait_valid(20, n);
        chk("mc_os_code", 32'(key_code), 2);
        tick(63);
        chk("mc_os_busy", 32'(busy), 1);
        tick(1);
        chk("mc_os_end", 32'(busy), 0);
        chk("mc_os_beep", 32'(beep), 0);
        key = 4'hF;
        tick(15);

        // One-shot retrigger at cycle 30.
        key = 4'b1110;
        wait_valid(20, n);
        chk("os_code0", 32'(key_code), 0);
        tick(19);
        key = 4'b1010;
        wait_valid(20, n);
        chk_rng("os_retrig_at", n + 19, 28, 32);
        chk("os_code2", 32'(key_code), 2);
        tick(63);
        chk("os_busy", 32'(busy), 1);
        tick(1);
        chk("os_end", 32'(busy), 0);
        chk("os_beep", 32'(beep), 0);
        key = 4'hF;
        tick(15);

        // Asynchronous reset mid-tone with the key held through it.
        mode = 2'd0;
        key  = 4'b1101;
        wait_valid(20, n);
        chk("rm_code", 32'(key_code), 1);
        tick(3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rm_beep", 32'(beep), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_valid", 32'(key_valid), 0);
        tick(2);
        sys_rst_n = 1'b1;
        wait_valid(20, n);
        chk_rng("rm_relat", n, 9, 11);
        chk("rm_recode", 32'(key_code), 1);
        key = 4'hF;
        wait_busy_low(20, n);
        chk("rm_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
